// File: rtl/dvp_bus_pkg.sv
// Shared AHB/APB bus definitions for the DVP register bridge.
package dvp_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ACCESS = 3'd2,
    ST_ERR1   = 3'd3,
    ST_ERR2   = 3'd4
  } bridge_state_e;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic       HRESP_OKAY  = 1'b0;
  localparam logic       HRESP_ERROR = 1'b1;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;

  function automatic logic is_word_xfer(input logic [2:0] hsize, input logic [1:0] haddr_lo);
    return (hsize == HSIZE_WORD) && (haddr_lo == 2'b00);
  endfunction

endpackage

// File: rtl/ahb_lite_apb_bridge.sv
// AHB-Lite slave to APB master bridge for the DVP register block.
// Word accesses only; anything else, a slave error or a PREADY timeout returns a two-cycle ERROR.
//
// state     | meaning
// ST_IDLE   | no APB activity, HREADYOUT=1, accepts an address phase
// ST_SETUP  | APB setup phase, PSEL=1 PENABLE=0, AHB stalled
// ST_ACCESS | APB access phase, waits for PREADY or timeout
// ST_ERR1   | first ERROR cycle, HRESP=1 HREADYOUT=0
// ST_ERR2   | second ERROR cycle, HRESP=1 HREADYOUT=1, accepts an address phase
module ahb_lite_apb_bridge
  import dvp_bus_pkg::*;
#(
  parameter int PADDR_W = 4,
  parameter int TIMEOUT = 256
) (
  input  logic               io_ahb_PCLK,
  input  logic               io_ahb_PRESET,
  input  logic               HSEL,
  input  logic [31:0]        HADDR,
  input  logic [1:0]         HTRANS,
  input  logic               HWRITE,
  input  logic [2:0]         HSIZE,
  input  logic [31:0]        HWDATA,
  input  logic               HREADY,
  output logic               HREADYOUT,
  output logic               HRESP,
  output logic [31:0]        HRDATA,
  output logic [PADDR_W-1:0] PADDR,
  output logic               PSEL,
  output logic               PENABLE,
  output logic               PWRITE,
  output logic [31:0]        PWDATA,
  input  logic               PREADY,
  input  logic [31:0]        PRDATA,
  input  logic               PSLVERROR
);

  localparam int               CNT_W    = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  bridge_state_e    state;
  logic [CNT_W-1:0] wait_cnt;
  logic             xfer_valid;
  logic             xfer_ok;
  logic             addr_open;
  logic             unused_haddr;

  assign xfer_valid = HSEL & HREADY & ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));
  assign xfer_ok    = is_word_xfer(HSIZE, HADDR[1:0]);
  // Only the two states that present HREADYOUT=1 may take a new address phase.
  assign addr_open  = (state == ST_IDLE) || (state == ST_ERR2);

  // HWDATA is held by the master while the bridge stalls, so it can be forwarded directly.
  assign PWDATA = PSEL ? HWDATA : 32'h0;

  assign unused_haddr = ^HADDR[31:PADDR_W+2];

  always_ff @(posedge io_ahb_PCLK or posedge io_ahb_PRESET) begin
    if (io_ahb_PRESET) begin
      state     <= ST_IDLE;
      HREADYOUT <= 1'b1;
      HRESP     <= HRESP_OKAY;
      HRDATA    <= 32'h0;
      PADDR     <= '0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_ERR2: begin
          state     <= ST_IDLE;
          HREADYOUT <= 1'b1;
          HRESP     <= HRESP_OKAY;
          if (addr_open && xfer_valid) begin
            PADDR  <= HADDR[PADDR_W+1:2];
            PWRITE <= HWRITE;
            if (xfer_ok) begin
              state     <= ST_SETUP;
              PSEL      <= 1'b1;
              PENABLE   <= 1'b0;
              HREADYOUT <= 1'b0;
              wait_cnt  <= '0;
            end else begin
              state     <= ST_ERR1;
              HREADYOUT <= 1'b0;
              HRESP     <= HRESP_ERROR;
            end
          end
        end

        ST_SETUP: begin
          state   <= ST_ACCESS;
          PENABLE <= 1'b1;
        end

        ST_ACCESS: begin
          if (PREADY) begin
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            if (PSLVERROR) begin
              state <= ST_ERR1;
              HRESP <= HRESP_ERROR;
            end else begin
              state     <= ST_IDLE;
              HREADYOUT <= 1'b1;
              HRESP     <= HRESP_OKAY;
              if (!PWRITE) HRDATA <= PRDATA;
            end
          end else if (wait_cnt == CNT_LAST) begin
            state   <= ST_ERR1;
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            HRESP   <= HRESP_ERROR;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        ST_ERR1: begin
          state     <= ST_ERR2;
          HREADYOUT <= 1'b1;
          HRESP     <= HRESP_ERROR;
        end

        default: begin
          state     <= ST_IDLE;
          HREADYOUT <= 1'b1;
          HRESP     <= HRESP_OKAY;
          PSEL      <= 1'b0;
          PENABLE   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/ahb_lite_apb_bridge.md
AHB_LITE_APB_BRIDGE -- requirements
Module: ahb_lite_apb_bridge

Interface
REQ-001 SHALL have parameter PADDR_W, default 4: APB word-address width (covers the 10 DVP registers).
REQ-002 SHALL have parameter TIMEOUT, default 256: maximum ACCESS cycles with PREADY low before abort.
REQ-003 SHALL have port io_ahb_PCLK, input, 1: single clock for both the AHB side and the APB side.
REQ-004 SHALL have port io_ahb_PRESET, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have AHB-Lite slave inputs: HSEL 1, HADDR 32, HTRANS 2, HWRITE 1, HSIZE 3, HWDATA 32, HREADY 1.
REQ-006 SHALL have AHB-Lite slave outputs: HREADYOUT 1, HRESP 1, HRDATA 32.
REQ-007 SHALL have APB master outputs: PADDR PADDR_W, PSEL 1, PENABLE 1, PWRITE 1, PWDATA 32.
REQ-008 SHALL have APB master inputs: PREADY 1, PRDATA 32, PSLVERROR 1.

Function
REQ-009 SHALL treat a transfer as valid when HSEL & HTRANS[1] & HREADY is high at a rising edge (address phase, cycle N).
REQ-010 SHALL register HADDR[PADDR_W+1:2] into PADDR and HWRITE into PWRITE at cycle N.
REQ-011 SHALL answer IDLE/BUSY transfers and unselected cycles with OKAY, zero wait states, and no APB activity.
REQ-012 SHALL implement FSM states IDLE, SETUP, ACCESS, ERR1, ERR2.
- IDLE -> SETUP on a valid word transfer.
- IDLE -> ERR1 on a valid transfer with HSIZE != 3'b010 or HADDR[1:0] != 0; no APB access in this case.
REQ-013 SHALL behave as follows in SETUP (N+1): PSEL=1, PENABLE=0, HREADYOUT=0; next state is ACCESS.
REQ-014 SHALL drive PSEL=1, PENABLE=1, HREADYOUT=0 in ACCESS and hold there while PREADY=0.
REQ-015 SHALL drive PWDATA from HWDATA in SETUP and ACCESS (HWDATA is stable while HREADYOUT=0) and hold PWDATA at 0 otherwise.
REQ-016 SHALL handle ACCESS completion (PREADY=1) as follows:
- PSLVERROR=0: capture PRDATA into HRDATA on reads, return to IDLE, HREADYOUT=1 with HRESP=0 in the following cycle.
- PSLVERROR=1: go to ERR1.
REQ-017 SHALL give minimum latency with PREADY tied high: address phase N, SETUP N+1, ACCESS N+2, HREADYOUT=1 with data at N+3.
REQ-018 SHALL, in ERR1, drive HRESP=1, HREADYOUT=0 and PSEL=PENABLE=0; in ERR2, drive HRESP=1, HREADYOUT=1, then go to IDLE.
REQ-019 SHALL sample an address phase coincident with the completing OKAY cycle or ERR2 as a new transfer (back-to-back: SETUP at N+4).
REQ-020 SHALL ignore HTRANS/HADDR while HREADYOUT=0, including in ERR1.
REQ-021 SHALL count ACCESS cycles with PREADY=0 in a counter of width clog2(TIMEOUT)+1, cleared on entering SETUP.
REQ-022 SHALL, when the counter reaches TIMEOUT-1 with PREADY still 0, deassert PSEL/PENABLE and enter ERR1.
REQ-023 SHALL hold HRDATA until the next completed read and SHALL NOT update it on writes or errors.

Reset
REQ-024 SHALL force the state to IDLE on io_ahb_PRESET=1, asynchronously, including mid-ACCESS.
REQ-025 SHALL reset outputs to: HREADYOUT=1, HRESP=0, HRDATA=0, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, timeout counter=0.
REQ-026 SHALL start accepting transfers on the first rising edge after io_ahb_PRESET deasserts.

Structure
REQ-027 SHALL take the FSM state enum, HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ), HRESP OKAY/ERROR and the HSIZE_WORD constant from shared package dvp_bus_pkg.
REQ-028 SHALL be a single module with no sub-module; timeout counter and FSM inline.

Verification
REQ-029 SHALL cover a single write: HADDR=0x08, HWDATA=0x0000_0005, PREADY=1 -> PSEL at N+1, PENABLE at N+2 with PADDR=2 and PWDATA=5, HREADYOUT=1 at N+3.
REQ-030 SHALL cover a read with wait states: HADDR=0x14, PREADY low 3 cycles, PRDATA=0x02D0_0500 -> HRDATA=0x02D0_0500 and HREADYOUT=1 one cycle after PREADY rises.
REQ-031 SHALL cover back-to-back NONSEQ write 0x10 then read 0x18 -> two APB accesses, second SETUP at N+4, no idle APB cycle lost.
REQ-032 SHALL cover a size error: HSIZE=3'b000 at 0x00 -> no PSEL, HRESP=1 for 2 cycles, HREADYOUT 0 then 1.
REQ-033 SHALL cover timeout: PREADY held 0 with TIMEOUT=4 -> PSEL drops after 4 ACCESS cycles, then a two-cycle ERROR response.
REQ-034 SHALL cover reset in ACCESS: assert io_ahb_PRESET -> PSEL=PENABLE=0 and HREADYOUT=1 before the next edge; a following write completes normally.
